shift_sequencer: RTL and testbench

Multi-cycle shift controller that performs an N-position shift (0–15) by iterating the existing single-position 16-bit `shifter` datapath block once per clock. It latches an operand, shift code and amount on a start pulse, steps the shifter until the count is exhausted, and returns the result with a one-cycle done pulse. It sits between the instruction controller and the register-file write path, replacing a wide barrel shifter at the cost of latency.

---
 rtl/shift_seq_pkg.sv | 17 +
 rtl/shifter.sv | 20 ++
 rtl/shift_sequencer.sv | 96 +++++++++
 tb/tb_shift_sequencer.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/shift_seq_pkg.sv
// Shared types and constants for the shift sequencer and its single-step shifter.
package shift_seq_pkg;

  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;

  localparam logic [1:0] OP_PASS = 2'b00;
  localparam logic [1:0] OP_LSL  = 2'b01;
  localparam logic [1:0] OP_LSR  = 2'b10;
  localparam logic [1:0] OP_ASR  = 2'b11;

endpackage

// File: rtl/shifter.sv
// Single-position 16-bit shifter datapath: pass, LSL, LSR or ASR by exactly one bit.
module shifter
  import shift_seq_pkg::*;
(
  input  logic [DATA_W-1:0] data_i,
  input  logic [1:0]        op_i,
  output logic [DATA_W-1:0] data_o
);

  always_comb begin
    data_o = data_i;
    case (op_i)
      OP_LSL:  data_o = {data_i[DATA_W-2:0], 1'b0};
      OP_LSR:  data_o = {1'b0, data_i[DATA_W-1:1]};
      OP_ASR:  data_o = {data_i[DATA_W-1], data_i[DATA_W-1:1]};
      default: data_o = data_i;
    endcase
  end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle N-position shifter built by stepping the single-position shifter once per clock.
// Optional SHIFT_SEQ_EARLY_EXIT_EN: finish as soon as the accumulator reaches a fixed point.
module shift_sequencer
  import shift_seq_pkg::*;
#(
  parameter int AMT_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [AMT_W-1:0]  amt,
  input  logic [DATA_W-1:0] din,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] dout
);

  state_e            state_q;
  logic [DATA_W-1:0] acc_q;
  logic [AMT_W-1:0]  cnt_q;
  logic [1:0]        opReg_q;
  logic              busy_q;
  logic              done_q;
  logic [DATA_W-1:0] dout_q;

  logic [DATA_W-1:0] shiftOut;
  logic              lastStep;

  shifter u_shifter (
    .data_i (acc_q),
    .op_i   (opReg_q),
    .data_o (shiftOut)
  );

`ifdef SHIFT_SEQ_EARLY_EXIT_EN
  // A fixed point cannot change on further steps, so the remaining count can be skipped.
  assign lastStep = (cnt_q == AMT_W'(1)) || (shiftOut == acc_q);
`else
  assign lastStep = (cnt_q == AMT_W'(1));
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      opReg_q <= OP_PASS;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dout_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            acc_q   <= din;
            cnt_q   <= amt;
            opReg_q <= op;
            busy_q  <= 1'b1;
            // Nothing to iterate: publish the operand straight away.
            if (amt == '0 || op == OP_PASS) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              dout_q  <= din;
            end else begin
              state_q <= SHIFT;
            end
          end
        end
        SHIFT: begin
          acc_q <= shiftOut;
          cnt_q <= cnt_q - AMT_W'(1);
          if (lastStep) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            dout_q  <= shiftOut;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign dout = dout_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: directed cases plus randomized operations
// compared against an arithmetic reference (honours SHIFT_SEQ_EARLY_EXIT_EN if defined).
module tb_shift_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [3:0]  amt;
  logic [15:0] din;
  logic        busy;
  logic        done;
  logic [15:0] dout;

  int assertCount = 0;
  int failCount   = 0;

  always #5 clk = ~clk;

  shift_sequencer #(.AMT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .amt   (amt),
    .din   (din),
    .busy  (busy),
    .done  (done),
    .dout  (dout)
  );

  // Reference result: the whole N-position shift done in one arithmetic operation.
  function automatic logic [15:0] refShift(logic [15:0] d, logic [1:0] o, int a);
    logic signed [15:0] s;
    s = d;
    case (o)
      2'b01:   return d << a;
      2'b10:   return d >> a;
      2'b11:   return s >>> a;
      default: return d;
    endcase
  endfunction

  // Cycles from acceptance until done is visible.
  function automatic int refLatency(logic [15:0] d, logic [1:0] o, int a);
    logic [15:0] v;
    if (o == 2'b00 || a == 0) return 1;
`ifdef SHIFT_SEQ_EARLY_EXIT_EN
    for (int j = 1; j <= a; j++) begin
      v = refShift(d, o, j - 1);
      if (v == 16'h0000 || (o == 2'b11 && v == 16'hFFFF)) return j + 1;
    end
`else
    v = d;
`endif
    return a + 1;
  endfunction

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    assertCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Issue one operation, optionally poke start while busy, and check latency, busy and result.
  task automatic applyStimulus(input logic [15:0] d, input logic [1:0] o, input logic [3:0] a,
                               input int pokeAt, input string tag);
    logic [15:0] expData;
    int          expLat;
    int          lat;
    expData = refShift(d, o, int'(a));
    expLat  = refLatency(d, o, int'(a));
    @(negedge clk);
    start = 1'b1; din = d; op = o; amt = a;
    @(posedge clk); #1;
    start = 1'b0; din = 16'($urandom); op = 2'($urandom); amt = 4'($urandom);
    lat = 1;
    checkOutput({tag, " busyRise"}, 16'(busy), 16'd1);
    while (done !== 1'b1 && lat < 40) begin
      start = (pokeAt != 0 && lat == pokeAt);
      if (start) begin
        din = 16'($urandom); op = 2'($urandom); amt = 4'($urandom);
      end
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    checkOutput({tag, " latency"}, 16'(lat), 16'(expLat));
    checkOutput({tag, " dout"}, dout, expData);
    @(posedge clk); #1;
    checkOutput({tag, " busyFall"}, 16'(busy), 16'd0);
    checkOutput({tag, " donePulse"}, 16'(done), 16'd0);
    checkOutput({tag, " doutHold"}, dout, expData);
  endtask

  initial begin
    logic [15:0] rd;
    logic [1:0]  ro;
    logic [3:0]  ra;
    int          rp;

    reset = 1'b1; start = 1'b0; op = 2'b00; amt = 4'd0; din = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset dout", dout, 16'h0000);
    checkOutput("reset busy", 16'(busy), 16'd0);
    checkOutput("reset done", 16'(done), 16'd0);
    @(negedge clk) reset = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      checkOutput("idle noDone", 16'(done), 16'd0);
    end

    applyStimulus(16'h0001, 2'b01, 4'd4, 0, "lsl4");
    applyStimulus(16'h8000, 2'b10, 4'd15, 0, "lsr15");
    applyStimulus(16'h8004, 2'b11, 4'd2, 0, "asr2");
    applyStimulus(16'h1234, 2'b01, 4'd0, 0, "amtZero");
    applyStimulus(16'hBEEF, 2'b00, 4'd7, 0, "pass7");
    applyStimulus(16'h00F0, 2'b01, 4'd6, 3, "pokeBusy");
    applyStimulus(16'hFFFF, 2'b11, 4'd15, 0, "asrAllOnes");
    applyStimulus(16'h0000, 2'b10, 4'd9, 0, "lsrZero");

    for (int i = 0; i < 16; i++) begin
      rd = 16'($urandom);
      if (i % 5 == 0) rd = 16'hFFFF;
      if (i % 7 == 0) rd = 16'h0000;
      ro = 2'($urandom);
      ra = 4'($urandom);
      rp = (ra != 0) ? int'($urandom_range(0, int'(ra))) : 0;
      applyStimulus(rd, ro, ra, rp, $sformatf("rand%0d", i));
    end

    // Reset during the second SHIFT cycle discards the operation.
    @(negedge clk);
    start = 1'b1; din = 16'h0003; op = 2'b01; amt = 4'd8;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checkOutput("midReset busy", 16'(busy), 16'd0);
    checkOutput("midReset dout", dout, 16'h0000);
    checkOutput("midReset done", 16'(done), 16'd0);
    repeat (12) begin
      @(posedge clk); #1;
      checkOutput("midReset noDone", 16'(done), 16'd0);
    end

    // Reset and start together: the request is dropped.
    @(negedge clk);
    reset = 1'b1; start = 1'b1; din = 16'h0F0F; op = 2'b01; amt = 4'd3;
    @(posedge clk); #1;
    reset = 1'b0; start = 1'b0;
    checkOutput("resetStart busy", 16'(busy), 16'd0);
    repeat (6) begin
      @(posedge clk); #1;
      checkOutput("resetStart noDone", 16'(done), 16'd0);
    end

    applyStimulus(16'hC001, 2'b10, 4'd3, 0, "afterReset");

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
